id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage owning the IF/ID and ID/EX pipeline registers, with valid/ready flow control.
//  Detects load-use hazards through a LOAD_LAT-deep in-flight-load scoreboard, so load latency is not hard-wired to one bubble.
//  Supports squash on branch redirect and counts stall cycles.
//  Sits between the IF stage and EX; the Controller and register file stay outside and consume ex_inst/ex_rs*.
// PARAMETERS
//  XLEN      32  data/PC width
//  RA_W      5   register-address width
//  LOAD_LAT  1   cycles (>=1) a load's rd stays unavailable after it enters EX; 1 = classic single bubble
//  CNT_W     16  stall-counter width
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous, active-high reset
//  if_valid     in   1      IF presents an instruction
//  if_inst      in   32     instruction from IF
//  if_pc        in   XLEN   PC of if_inst
//  id_ready     out  1      IF/ID register can accept this cycle (also PC-write enable for IF)
//  ex_ready     in   1      EX can accept; 0 freezes ID/EX and the scoreboard
//  flush        in   1      branch/jump redirect from EX: squash IF/ID and the ID/EX input
//  ex_valid     out  1      ID/EX holds a live instruction
//  ex_inst      out  32     registered instruction
//  ex_pc        out  XLEN   registered PC
//  ex_rs1       out  RA_W   inst[19:15], or 0 if the opcode does not read rs1
//  ex_rs2       out  RA_W   inst[24:20], or 0 if the opcode does not read rs2
//  ex_rd        out  RA_W   inst[11:7], or 0 if the opcode does not write rd
//  ex_is_load   out  1      opcode == LOAD (7'b0000011)
//  stall        out  1      load-use hazard is holding IF/ID this cycle
//  stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  Reset (async): d_valid, ex_valid, ex_is_load, stall_cnt, and all scoreboard entries = 0; ex_inst = 32'h00000013 (NOP); ex_pc, ex_rs*, ex_rd = 0.
//  Uses: rs1 for all opcodes except LUI/AUIPC/JAL; rs2 for R-type, STORE and BRANCH only; rd writes for all except STORE/BRANCH.
//  hazard = d_valid & any scoreboard entry k (valid_k & rd_k!=0 & (rd_k==d_rs1 | rd_k==d_rs2)); d_rs* are the use-qualified fields.
//  advance = d_valid & !hazard & ex_ready & !flush.
//  id_ready = !d_valid | advance | flush (combinational).
//  IF/ID update on clk:
//    flush -> d_valid <= 0, and if_inst is NOT captured (redirect in flight).
//    Else if id_ready & if_valid -> capture; else if advance -> d_valid <= 0; else hold.
//  ID/EX update only when ex_ready:
//    advance -> load the decode fields.
//    Otherwise (hazard, flush or empty) -> insert a bubble (ex_valid=0, ex_rd=0, ex_is_load=0).
//  If ex_ready=0, ID/EX holds regardless of flush; flush still clears IF/ID.
//  Scoreboard: entry 0 = {ex_valid & ex_is_load, ex_rd}.
//    Entries 1..LOAD_LAT-1 form a shift register fed from entry 0; it shifts only when ex_ready=1, and the freshly vacated stage takes 0.
//    With LOAD_LAT=1 there is no register, only entry 0.
//  stall = hazard & !flush. stall_cnt increments while stall=1 and saturates at all-ones.
//  Latency: IF to EX is 2 edges when no hazard occurs. A dependent instruction immediately after a load sees exactly LOAD_LAT bubbles.
//  Simultaneous flush & hazard: flush wins, stall=0, no count.
//  Reset mid-stall: everything returns to reset values; first post-reset fetch behaves as cold start.
// STRUCTURE
//  Constants.vh: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_R) and NOP_INST.
//  Sub-module id_load_scoreboard (params RA_W, LOAD_LAT): holds entries 1..LOAD_LAT-1, outputs hit flags for two source addresses.
//  Everything else lives in id_stage_pipe.
// TESTING
//  1. LOAD_LAT=1: lw x5,0(x1); add x6,x5,x2 -> one cycle stall=1; one bubble in EX (ex_valid=0); add reaches EX 3 edges after lw; stall_cnt=1.
//  2. LOAD_LAT=3, same pair -> exactly 3 bubbles; stall_cnt=3; an independent instruction between them reduces the bubbles to 2.
//  3. lw x0,0(x1); add x6,x0,x2 -> no stall. Also sw x5 after lw x7 -> no hazard (rd mismatch).
//  4. flush asserted during a load-use stall -> next edge d_valid=0, ex_valid=0, stall=0; if_inst offered that cycle is dropped; stall_cnt unchanged.
//  5. ex_ready=0 for 4 cycles with ID/EX holding lw x5 -> ID/EX and scoreboard frozen; id_ready=0 once IF/ID is full; outputs unchanged.
//  6. Assert rst mid-stall (async, between edges) -> outputs reach reset values immediately; ex_inst=32'h13; stall_cnt=0.
//  7. Force 2^CNT_W+2 stall cycles (CNT_W=4) -> stall_cnt saturates at 4'hF.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared constants and decode helpers for the ID stage.
//   OP_*      : RV32 major opcodes the decode stage cares about
//   NOP_INST  : addi x0,x0,0 -- value ID/EX holds after reset
//   use_t     : which register fields an opcode reads/writes
package id_stage_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } use_t;

  function automatic use_t decode_use(input logic [6:0] op);
    use_t u;
    u.rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    u.rs2 = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    u.rd  = !(op == OP_STORE || op == OP_BRANCH);
    return u;
  endfunction

endpackage

// File: rtl/id_load_scoreboard.sv
// In-flight load tracker. Entry 0 (the load currently in EX) is supplied by
// the ID/EX register; this block keeps entries 1..LOAD_LAT-1 and reports
// whether either source register matches any live entry.
//   clk, rst         : clock, async active-high reset
//   shift_en         : EX accepted this cycle (tail advances)
//   e0_vld, e0_rd    : entry 0 = load resident in EX and its rd
//   rs1, rs2         : use-qualified source fields of the instruction in ID
//   hit_rs1, hit_rs2 : source matches a pending non-x0 load destination
module id_load_scoreboard #(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            shift_en,
  input  logic            e0_vld,
  input  logic [RA_W-1:0] e0_rd,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output logic            hit_rs1,
  output logic            hit_rs2
);

  logic tail_hit1, tail_hit2;

  generate
    if (LOAD_LAT > 1) begin : g_tail
      logic [LOAD_LAT-1:1]           vld_pipe;
      logic [LOAD_LAT-1:1][RA_W-1:0] rd_pipe;

      // Entry 1 takes whatever leaves EX; when EX moved a bubble in, entry 0
      // already reads invalid, so zeros shift in behind the load.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe <= '0;
          rd_pipe  <= '0;
        end else if (shift_en) begin
          vld_pipe[1] <= e0_vld;
          rd_pipe[1]  <= e0_rd;
          for (int k = 2; k < LOAD_LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            rd_pipe[k]  <= rd_pipe[k-1];
          end
        end
      end

      always_comb begin
        tail_hit1 = 1'b0;
        tail_hit2 = 1'b0;
        for (int k = 1; k < LOAD_LAT; k++) begin
          if (vld_pipe[k] && rd_pipe[k] != '0) begin
            tail_hit1 = tail_hit1 | (rd_pipe[k] == rs1);
            tail_hit2 = tail_hit2 | (rd_pipe[k] == rs2);
          end
        end
      end
    end else begin : g_no_tail
      logic unused_tail;
      assign unused_tail = ^{clk, rst, shift_en};
      assign tail_hit1 = 1'b0;
      assign tail_hit2 = 1'b0;
    end
  endgenerate

  // x0 never creates a dependency.
  assign hit_rs1 = (e0_vld && e0_rd != '0 && e0_rd == rs1) || tail_hit1;
  assign hit_rs2 = (e0_vld && e0_rd != '0 && e0_rd == rs2) || tail_hit2;

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: owns IF/ID and ID/EX registers with valid/ready flow control,
// load-use hazard detection over LOAD_LAT cycles, branch squash, stall count.
//   clk, rst          : clock, async active-high reset
//   if_valid/inst/pc  : instruction offered by IF
//   id_ready          : IF/ID accepts this cycle (PC write enable for IF)
//   ex_ready          : EX accepts; low freezes ID/EX and the scoreboard
//   flush             : redirect from EX, squashes IF/ID and the ID/EX input
//   ex_*              : ID/EX register contents (rs/rd zeroed when unused)
//   stall, stall_cnt  : load-use hold this cycle, saturating stall count
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             ex_valid,
  output logic [31:0]      ex_inst,
  output logic [XLEN-1:0]  ex_pc,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_is_load,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            d_valid;
  logic [31:0]     d_inst;
  logic [XLEN-1:0] d_pc;
  use_t            d_use;
  logic [RA_W-1:0] d_rs1, d_rs2, d_rd;
  logic            hit_rs1, hit_rs2, hazard, advance;

  assign d_use = decode_use(d_inst[6:0]);
  assign d_rs1 = d_use.rs1 ? RA_W'(d_inst[19:15]) : '0;
  assign d_rs2 = d_use.rs2 ? RA_W'(d_inst[24:20]) : '0;
  assign d_rd  = d_use.rd  ? RA_W'(d_inst[11:7])  : '0;

  id_load_scoreboard #(.RA_W(RA_W), .LOAD_LAT(LOAD_LAT)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .shift_en (ex_ready),
    .e0_vld   (ex_valid & ex_is_load),
    .e0_rd    (ex_rd),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .hit_rs1  (hit_rs1),
    .hit_rs2  (hit_rs2)
  );

  assign hazard   = d_valid & (hit_rs1 | hit_rs2);
  assign advance  = d_valid & ~hazard & ex_ready & ~flush;
  assign id_ready = ~d_valid | advance | flush;
  assign stall    = hazard & ~flush;

  // IF/ID: a redirect drops both the held instruction and the one on the
  // wire, since that fetch came from the wrong path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid <= 1'b0;
      d_inst  <= NOP_INST;
      d_pc    <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (id_ready && if_valid) begin
      d_valid <= 1'b1;
      d_inst  <= if_inst;
      d_pc    <= if_pc;
    end else if (advance) begin
      d_valid <= 1'b0;
    end
  end

  // ID/EX: moves only when EX accepts; anything but a clean advance becomes
  // a bubble so the scoreboard sees the load leave EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_inst    <= NOP_INST;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
    end else if (ex_ready) begin
      if (advance) begin
        ex_valid   <= 1'b1;
        ex_inst    <= d_inst;
        ex_pc      <= d_pc;
        ex_rs1     <= d_rs1;
        ex_rs2     <= d_rs2;
        ex_rd      <= d_rd;
        ex_is_load <= (d_inst[6:0] == OP_LOAD);
      end else begin
        ex_valid   <= 1'b0;
        ex_rd      <= '0;
        ex_is_load <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (LOAD_LAT=1/CNT_W=4 and
// LOAD_LAT=3/CNT_W=16), directed vector tables, saturation and async reset
// sequences, then random traffic against a reference model.
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  localparam logic [31:0] LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD5  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD0  = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] LW7   = 32'h0000A383; // lw   x7,0(x1)
  localparam logic [31:0] SW5   = 32'h0050A023; // sw   x5,0(x1)
  localparam logic [31:0] ADDI9 = 32'h00100493; // addi x9,x0,1
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv0, iv1, er0, er1, fl0, fl1;
  logic [31:0] ii0, ii1, ip0, ip1;
  logic idr0, idr1, exv0, exv1, exl0, exl1, st0, st1;
  logic [31:0] ei0, ei1, ep0, ep1;
  logic [4:0] r10, r11, r20, r21, rd0, rd1;
  logic [3:0] cnt0;
  logic [15:0] cnt1;

  id_stage_pipe #(.XLEN(32), .RA_W(5), .LOAD_LAT(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .if_valid(iv0), .if_inst(ii0), .if_pc(ip0),
    .id_ready(idr0), .ex_ready(er0), .flush(fl0), .ex_valid(exv0),
    .ex_inst(ei0), .ex_pc(ep0), .ex_rs1(r10), .ex_rs2(r20), .ex_rd(rd0),
    .ex_is_load(exl0), .stall(st0), .stall_cnt(cnt0));

  id_stage_pipe #(.XLEN(32), .RA_W(5), .LOAD_LAT(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .if_valid(iv1), .if_inst(ii1), .if_pc(ip1),
    .id_ready(idr1), .ex_ready(er1), .flush(fl1), .ex_valid(exv1),
    .ex_inst(ei1), .ex_pc(ep1), .ex_rs1(r11), .ex_rs2(r21), .ex_rd(rd1),
    .ex_is_load(exl1), .stall(st1), .stall_cnt(cnt1));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic idr, st, exv, exl;
    logic [31:0] inst, pc;
    logic [4:0] r1, r2, rd;
    logic [15:0] cnt;
  } obs_t;

  function automatic obs_t get_obs(input int m);
    obs_t o;
    if (m == 0) begin
      o.idr = idr0; o.st = st0; o.exv = exv0; o.exl = exl0; o.inst = ei0; o.pc = ep0;
      o.r1 = r10; o.r2 = r20; o.rd = rd0; o.cnt = {12'h0, cnt0};
    end else begin
      o.idr = idr1; o.st = st1; o.exv = exv1; o.exl = exl1; o.inst = ei1; o.pc = ep1;
      o.r1 = r11; o.r2 = r21; o.rd = rd1; o.cnt = cnt1;
    end
    return o;
  endfunction

  task automatic drive(input int m, input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    if (m == 0) begin iv0 = v; ii0 = i; ip0 = p; er0 = r; fl0 = f; end
    else        begin iv1 = v; ii1 = i; ip1 = p; er1 = r; fl1 = f; end
  endtask

  task automatic chk_reset(input string tag);
    obs_t o;
    for (int m = 0; m < 2; m++) begin
      o = get_obs(m);
      chk($sformatf("%s%0d ex_valid", tag, m), o.exv, 0);
      chk($sformatf("%s%0d ex_inst", tag, m), o.inst, 32'h13);
      chk($sformatf("%s%0d ex_pc", tag, m), o.pc, 0);
      chk($sformatf("%s%0d ex_rs", tag, m), {o.r1, o.r2, o.rd}, 0);
      chk($sformatf("%s%0d ex_is_load", tag, m), o.exl, 0);
      chk($sformatf("%s%0d stall", tag, m), o.st, 0);
      chk($sformatf("%s%0d id_ready", tag, m), o.idr, 1);
      chk($sformatf("%s%0d stall_cnt", tag, m), o.cnt, 0);
    end
  endtask

  // ---------------- directed vector tables ----------------
  typedef struct {
    logic iv; logic [31:0] inst; logic er, fl;
    logic e_idr, e_st, e_exv; logic [4:0] e_rd; int e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [31:0] inst, input logic er, input logic fl,
                              input logic idr, input logic st, input logic exv,
                              input logic [4:0] rd, input int cnt);
    vec_t v;
    v.iv = iv; v.inst = inst; v.er = er; v.fl = fl;
    v.e_idr = idr; v.e_st = st; v.e_exv = exv; v.e_rd = rd; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic run_tab(input int m, input string tag, input vec_t t[$]);
    obs_t o;
    foreach (t[i]) begin
      drive(m, t[i].iv, t[i].inst, 32'h100 + i * 4, t[i].er, t[i].fl);
      @(negedge clk);
      o = get_obs(m);
      chk($sformatf("%s[%0d] id_ready", tag, i), o.idr, t[i].e_idr);
      chk($sformatf("%s[%0d] stall", tag, i), o.st, t[i].e_st);
      @(posedge clk); #1;
      o = get_obs(m);
      chk($sformatf("%s[%0d] ex_valid", tag, i), o.exv, t[i].e_exv);
      chk($sformatf("%s[%0d] ex_rd", tag, i), o.rd, t[i].e_rd);
      chk($sformatf("%s[%0d] stall_cnt", tag, i), o.cnt, t[i].e_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  // Loads that have left EX are remembered with the number of accepted EX
  // cycles since they left; a register is busy while that age < LOAD_LAT.
  int lat[2] = '{1, 3};
  int cmax[2] = '{15, 65535};
  logic m_dv[2], m_ev[2], m_el[2];
  logic [31:0] m_di[2], m_dp[2], m_ei[2], m_ep[2];
  logic [4:0] m_r1[2], m_r2[2], m_rd[2];
  int m_cnt[2];
  int fl_age[2][8];
  logic [4:0] fl_rd[2][8];

  function automatic logic [4:0] src1(input logic [31:0] i);
    case (i[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: return 5'd0;
      default: return i[19:15];
    endcase
  endfunction
  function automatic logic [4:0] src2(input logic [31:0] i);
    case (i[6:0])
      OP_R, OP_STORE, OP_BRANCH: return i[24:20];
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic [4:0] dst(input logic [31:0] i);
    case (i[6:0])
      OP_STORE, OP_BRANCH: return 5'd0;
      default: return i[11:7];
    endcase
  endfunction

  function automatic logic busy(input int m, input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (m_ev[m] && m_el[m] && m_rd[m] == r) return 1'b1;
    for (int i = 0; i < 8; i++)
      if (fl_age[m][i] > 0 && fl_age[m][i] < lat[m] && fl_rd[m][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_haz(input int m);
    return m_dv[m] && (busy(m, src1(m_di[m])) || busy(m, src2(m_di[m])));
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_dv[m] = 0; m_ev[m] = 0; m_el[m] = 0; m_di[m] = NOP; m_dp[m] = 0;
      m_ei[m] = NOP; m_ep[m] = 0; m_r1[m] = 0; m_r2[m] = 0; m_rd[m] = 0; m_cnt[m] = 0;
      for (int i = 0; i < 8; i++) begin fl_age[m][i] = 0; fl_rd[m][i] = 0; end
    end
  endtask

  task automatic model_step(input int m, input logic iv, input logic [31:0] inst,
                            input logic [31:0] pc, input logic er, input logic fl);
    logic hz, adv, idr;
    bit placed;
    hz  = m_haz(m);
    adv = m_dv[m] && !hz && er && !fl;
    idr = !m_dv[m] || adv || fl;
    if (hz && !fl && m_cnt[m] < cmax[m]) m_cnt[m]++;
    if (er) begin
      for (int i = 0; i < 8; i++)
        if (fl_age[m][i] > 0) begin
          fl_age[m][i]++;
          if (fl_age[m][i] >= lat[m]) fl_age[m][i] = 0;
        end
      if (m_ev[m] && m_el[m] && lat[m] > 1) begin
        placed = 0;
        for (int i = 0; i < 8; i++)
          if (!placed && fl_age[m][i] == 0) begin
            fl_age[m][i] = 1; fl_rd[m][i] = m_rd[m]; placed = 1;
          end
      end
      if (adv) begin
        m_ev[m] = 1; m_ei[m] = m_di[m]; m_ep[m] = m_dp[m];
        m_r1[m] = src1(m_di[m]); m_r2[m] = src2(m_di[m]); m_rd[m] = dst(m_di[m]);
        m_el[m] = (m_di[m][6:0] == OP_LOAD);
      end else begin
        m_ev[m] = 0; m_rd[m] = 0; m_el[m] = 0;
      end
    end
    if (fl) m_dv[m] = 0;
    else if (idr && iv) begin m_dv[m] = 1; m_di[m] = inst; m_dp[m] = pc; end
    else if (adv) m_dv[m] = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, d;
    int k;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    k = $urandom_range(0, 6);
    case (k)
      0: return {12'h0, a, 3'b010, d, OP_LOAD};
      1: return {7'h0, b, a, 3'b000, d, OP_R};
      2: return {7'h0, b, a, 3'b010, 5'h0, OP_STORE};
      3: return {7'h0, b, a, 3'b000, 5'h0, OP_BRANCH};
      4: return {20'h12345, d, OP_LUI};
      5: return {12'h001, a, 3'b000, d, 7'h13};
      default: return {20'h00000, d, OP_JAL};
    endcase
  endfunction

  vec_t t0[$], t1[$];
  logic r_iv[2], r_er[2], r_fl[2];
  logic [31:0] r_in[2], r_pc[2];

  initial begin
    obs_t o;
    rst = 1'b1;
    drive(0, 0, NOP, 0, 1, 0);
    drive(1, 0, NOP, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");

    // LOAD_LAT=1: single bubble, x0/rd-mismatch cases, flush in stall, EX freeze
    t0.push_back(mk(1, LW5,   1, 0, 1, 0, 0, 0, 0));
    t0.push_back(mk(1, ADD5,  1, 0, 1, 0, 1, 5, 0));
    t0.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 1));
    t0.push_back(mk(1, NOP,   1, 0, 1, 0, 1, 6, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 1, 0, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, LW0,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, ADD0,  1, 0, 1, 0, 1, 0, 1));
    t0.push_back(mk(1, LW7,   1, 0, 1, 0, 1, 6, 1));
    t0.push_back(mk(1, SW5,   1, 0, 1, 0, 1, 7, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 1, 0, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, LW5,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, ADD5,  1, 0, 1, 0, 1, 5, 1));
    t0.push_back(mk(1, NOP,   1, 1, 1, 0, 0, 0, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, LW5,   1, 0, 1, 0, 0, 0, 1));
    t0.push_back(mk(1, ADDI9, 1, 0, 1, 0, 1, 5, 1));
    for (int k = 0; k < 4; k++) t0.push_back(mk(1, NOP, 0, 0, 0, 0, 1, 5, 1));
    t0.push_back(mk(1, NOP,   1, 0, 1, 0, 1, 9, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 1, 0, 1));
    t0.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 1));
    run_tab(0, "lat1", t0);

    // LOAD_LAT=3: three bubbles, then two with an independent op in between
    t1.push_back(mk(1, LW5,   1, 0, 1, 0, 0, 0, 0));
    t1.push_back(mk(1, ADD5,  1, 0, 1, 0, 1, 5, 0));
    t1.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 1));
    t1.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 2));
    t1.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 3));
    t1.push_back(mk(1, NOP,   1, 0, 1, 0, 1, 6, 3));
    t1.push_back(mk(0, NOP,   1, 0, 1, 0, 1, 0, 3));
    t1.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 3));
    t1.push_back(mk(1, LW5,   1, 0, 1, 0, 0, 0, 3));
    t1.push_back(mk(1, ADDI9, 1, 0, 1, 0, 1, 5, 3));
    t1.push_back(mk(1, ADD5,  1, 0, 1, 0, 1, 9, 3));
    t1.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 4));
    t1.push_back(mk(1, NOP,   1, 0, 0, 1, 0, 0, 5));
    t1.push_back(mk(1, NOP,   1, 0, 1, 0, 1, 6, 5));
    t1.push_back(mk(0, NOP,   1, 0, 1, 0, 1, 0, 5));
    t1.push_back(mk(0, NOP,   1, 0, 1, 0, 0, 0, 5));
    run_tab(1, "lat3", t1);

    // Saturation: load stuck in EX with a dependent in ID stalls every cycle
    drive(0, 1, LW5, 32'h200, 1, 0);
    @(posedge clk); #1;
    drive(0, 1, ADD5, 32'h204, 1, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 18; k++) begin
      drive(0, 1, NOP, 32'h208, 0, 0);
      @(negedge clk);
      chk($sformatf("sat[%0d] stall", k), st0, 1);
      @(posedge clk); #1;
      chk($sformatf("sat[%0d] stall_cnt", k), cnt0, (1 + k > 15) ? 15 : 1 + k);
      chk($sformatf("sat[%0d] ex_rd", k), rd0, 5);
    end

    // Async reset while stalled, between clock edges
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    drive(0, 0, NOP, 0, 1, 0);
    drive(1, 0, NOP, 0, 1, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("cold");
    model_reset();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        r_iv[m] = ($urandom_range(0, 3) != 0);
        r_in[m] = rand_inst();
        r_pc[m] = $urandom;
        r_er[m] = ($urandom_range(0, 9) != 0);
        r_fl[m] = ($urandom_range(0, 15) == 0);
        drive(m, r_iv[m], r_in[m], r_pc[m], r_er[m], r_fl[m]);
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        logic hz;
        hz = m_haz(m);
        o = get_obs(m);
        chk($sformatf("rnd%0d[%0d] stall", m, c), o.st, hz && !r_fl[m]);
        chk($sformatf("rnd%0d[%0d] id_ready", m, c), o.idr,
            !m_dv[m] || (m_dv[m] && !hz && r_er[m] && !r_fl[m]) || r_fl[m]);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_step(m, r_iv[m], r_in[m], r_pc[m], r_er[m], r_fl[m]);
      #1;
      for (int m = 0; m < 2; m++) begin
        o = get_obs(m);
        chk($sformatf("rnd%0d[%0d] ex_valid", m, c), o.exv, m_ev[m]);
        chk($sformatf("rnd%0d[%0d] ex_rd/load", m, c), {o.rd, o.exl}, {m_rd[m], m_el[m]});
        chk($sformatf("rnd%0d[%0d] stall_cnt", m, c), o.cnt, m_cnt[m]);
        if (m_ev[m]) begin
          chk($sformatf("rnd%0d[%0d] ex_inst", m, c), o.inst, m_ei[m]);
          chk($sformatf("rnd%0d[%0d] ex_pc", m, c), o.pc, m_ep[m]);
          chk($sformatf("rnd%0d[%0d] ex_rs", m, c), {o.r1, o.r2}, {m_r1[m], m_r2[m]});
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
